pwm_gen: RTL and testbench

Synthesizable PWM / level / single-pulse generator driving one output pin (motor, servo, LED channels). Accepts configuration over a valid/ready port, holds it in a one-deep shadow, and applies it glitch-free at period or pulse boundaries. Its output is the line sampled by the bench PWM monitor for level, duty-cycle and pulse-width checks.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_if.sv | 25 ++
 rtl/pwm_shadow.sv | 51 +++++
 rtl/pwm_gen.sv | 161 ++++++++++++++++
 tb/tb_pwm_gen.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode constants and FSM state encoding for the PWM / level /
// single-pulse generator.
package pwm_pkg;

    // Configuration modes carried on cfg_mode
    localparam logic [1:0] PWM_MODE_OFF   = 2'd0;
    localparam logic [1:0] PWM_MODE_ON    = 2'd1;
    localparam logic [1:0] PWM_MODE_PWM   = 2'd2;
    localparam logic [1:0] PWM_MODE_PULSE = 2'd3;

    // Generator states: IDLE (output low), HIGH (output high), RUN (periodic PWM),
    // PULSE (single pulse high), DONE (pulse finished, output low)
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HIGH  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PULSE = 3'd3,
        ST_DONE  = 3'd4
    } pwm_state_e;

endpackage

// File: rtl/pwm_if.sv
// pwm_if: configuration handshake plus generator outputs for one PWM channel.
interface pwm_if #(parameter int W = 16);

    logic         cfg_valid;
    logic         cfg_ready;
    logic [1:0]   cfg_mode;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_duty;
    logic         data;
    logic         period_start;
    logic         busy;

    // Controller side: offers configs, observes the generated line
    modport master (
        output cfg_valid, cfg_mode, cfg_period, cfg_duty,
        input  cfg_ready, data, period_start, busy
    );

    // Generator side
    modport slave (
        input  cfg_valid, cfg_mode, cfg_period, cfg_duty,
        output cfg_ready, data, period_start, busy
    );

endinterface

// File: rtl/pwm_shadow.sv
// pwm_shadow: one-deep holding register for a config accepted while the
// generator is mid-period or mid-pulse. Emptied by the take strobe.
module pwm_shadow
    import pwm_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_take,
    input  logic [1:0]   i_mode,
    input  logic [W-1:0] i_period,
    input  logic [W-1:0] i_duty,
    output logic         o_pend_valid,
    output logic [1:0]   o_pend_mode,
    output logic [W-1:0] o_pend_period,
    output logic [W-1:0] o_pend_duty
);

    logic         r_valid;
    logic [1:0]   r_mode;
    logic [W-1:0] r_period;
    logic [W-1:0] r_duty;

    // Load when empty, clear when the generator consumes the entry; the two can
    // never coincide because take only happens while the entry is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_mode   <= PWM_MODE_OFF;
            r_period <= '0;
            r_duty   <= '0;
        end else if (i_valid && !r_valid) begin
            r_valid  <= 1'b1;
            r_mode   <= i_mode;
            r_period <= i_period;
            r_duty   <= i_duty;
        end else if (i_take) begin
            r_valid  <= 1'b0;
        end
    end

    assign o_ready       = !r_valid;
    assign o_pend_valid  = r_valid;
    assign o_pend_mode   = r_mode;
    assign o_pend_period = r_period;
    assign o_pend_duty   = r_duty;

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: PWM / constant level / single-pulse generator. New configs apply
// immediately from a static state, or at the next period/pulse boundary while
// running, so the output never glitches mid-period.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int W = 16
) (
    input  logic clk,
    input  logic rst,
    pwm_if.slave bus
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    pwm_state_e   r_state;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_period;
    logic [W-1:0] r_duty;
    logic         r_data;
    logic         r_period_start;
    logic         r_busy;

    logic         w_shadow_ready;
    logic         w_pend_valid;
    logic [1:0]   w_pend_mode;
    logic [W-1:0] w_pend_period;
    logic [W-1:0] w_pend_duty;

    logic         w_accept;
    logic         w_static;
    logic         w_run_bnd;
    logic         w_pulse_bnd;
    logic         w_boundary;
    logic         w_take;
    logic         w_direct;
    logic         w_load;
    logic         w_apply;
    logic [1:0]   w_app_mode;
    logic [W-1:0] w_app_period;
    logic [W-1:0] w_app_duty;
    logic [W-1:0] w_cnt_inc;

    assign w_accept    = bus.cfg_valid && w_shadow_ready;
    assign w_static    = (r_state == ST_IDLE) || (r_state == ST_HIGH) || (r_state == ST_DONE);
    // Last cycle of a PWM period / last high cycle of a pulse
    assign w_run_bnd   = (r_state == ST_RUN)   && (r_cnt == r_period - ONE);
    assign w_pulse_bnd = (r_state == ST_PULSE) && (r_cnt == r_duty - ONE);
    assign w_boundary  = w_run_bnd || w_pulse_bnd;
    // A pending entry always wins at a boundary; an accept can only happen when
    // the shadow is empty, so a boundary accept bypasses the shadow.
    assign w_take      = w_boundary && w_pend_valid;
    assign w_direct    = w_accept && (w_static || w_boundary);
    assign w_load      = w_accept && !w_direct;
    assign w_apply     = w_take || w_direct;

    assign w_app_mode   = w_take ? w_pend_mode   : bus.cfg_mode;
    assign w_app_period = w_take ? w_pend_period : bus.cfg_period;
    assign w_app_duty   = w_take ? w_pend_duty   : bus.cfg_duty;
    assign w_cnt_inc    = r_cnt + ONE;

    pwm_shadow #(.W(W)) u_shadow (
        .clk           (clk),
        .rst           (rst),
        .i_valid       (w_load),
        .o_ready       (w_shadow_ready),
        .i_take        (w_take),
        .i_mode        (bus.cfg_mode),
        .i_period      (bus.cfg_period),
        .i_duty        (bus.cfg_duty),
        .o_pend_valid  (w_pend_valid),
        .o_pend_mode   (w_pend_mode),
        .o_pend_period (w_pend_period),
        .o_pend_duty   (w_pend_duty)
    );

    // Generator FSM: applies configs, advances the counter, registers all outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_period       <= '0;
            r_duty         <= '0;
            r_data         <= 1'b0;
            r_period_start <= 1'b0;
            r_busy         <= 1'b0;
        end else if (w_apply) begin
            r_cnt          <= '0;
            r_period       <= w_app_period;
            r_duty         <= w_app_duty;
            r_period_start <= 1'b0;
            r_busy         <= 1'b0;
            case (w_app_mode)
                PWM_MODE_OFF: begin
                    r_state <= ST_IDLE;
                    r_data  <= 1'b0;
                end
                PWM_MODE_ON: begin
                    r_state <= ST_HIGH;
                    r_data  <= 1'b1;
                end
                PWM_MODE_PWM: begin
                    // A zero period has nothing to count over: park low
                    if (w_app_period == '0) begin
                        r_state <= ST_IDLE;
                        r_data  <= 1'b0;
                    end else begin
                        r_state        <= ST_RUN;
                        r_data         <= (w_app_duty != '0);
                        r_period_start <= 1'b1;
                        r_busy         <= 1'b1;
                    end
                end
                default: begin
                    // Zero-width pulse finishes before it starts
                    if (w_app_duty == '0) begin
                        r_state <= ST_DONE;
                        r_data  <= 1'b0;
                    end else begin
                        r_state <= ST_PULSE;
                        r_data  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
            endcase
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_run_bnd) begin
                        r_cnt          <= '0;
                        r_data         <= (r_duty != '0);
                        r_period_start <= 1'b1;
                    end else begin
                        r_cnt          <= w_cnt_inc;
                        r_data         <= (w_cnt_inc < r_duty);
                        r_period_start <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    if (w_pulse_bnd) begin
                        r_state <= ST_DONE;
                        r_cnt   <= '0;
                        r_data  <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                default: begin
                    r_period_start <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_ready    = w_shadow_ready;
    assign bus.data         = r_data;
    assign bus.period_start = r_period_start;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed scenarios plus randomized traffic for pwm_gen, checked
// against a time-based reference model (output derived from elapsed cycles
// since the config took effect, modulo the period).
module tb_pwm_gen;
    import pwm_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_if #(.W(W)) bus ();

    pwm_gen #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: active config and the cycle index where its phase 0 is
    int         cyc     = 0;
    logic [1:0] m_mode  = PWM_MODE_OFF;
    int         m_period = 0;
    int         m_duty  = 0;
    int         m_start = 0;
    bit         m_pend  = 1'b0;
    logic [1:0] p_mode  = PWM_MODE_OFF;
    int         p_period = 0;
    int         p_duty  = 0;

    // Expected {data, period_start, busy, cfg_ready} for the current cycle
    function automatic logic [3:0] model_out();
        int  ph;
        bit  d, ps, b;
        ph = cyc - m_start;
        d = 1'b0; ps = 1'b0; b = 1'b0;
        case (m_mode)
            PWM_MODE_ON:  d = 1'b1;
            PWM_MODE_PWM: if (m_period > 0) begin
                d  = (ph % m_period) < m_duty;
                ps = (ph % m_period) == 0;
                b  = 1'b1;
            end
            PWM_MODE_PULSE: begin
                d = ph < m_duty;
                b = ph < m_duty;
            end
            default: ;
        endcase
        return {d, ps, b, !m_pend};
    endfunction

    task automatic apply_cfg(input logic [1:0] mode, input int period, input int duty);
        m_mode   = mode;
        m_period = period;
        m_duty   = duty;
        m_start  = cyc + 1;
    endtask

    // One clock: update the model from the inputs seen at the edge, then
    // return at the following negedge where outputs are sampled.
    task automatic tick();
        int ph;
        bit acc, act_pwm, act_pulse, bnd;
        @(posedge clk);
        if (rst) begin
            m_mode = PWM_MODE_OFF; m_period = 0; m_duty = 0;
            m_start = cyc + 1; m_pend = 1'b0;
        end else begin
            ph        = cyc - m_start;
            acc       = bus.cfg_valid && !m_pend;
            act_pwm   = (m_mode == PWM_MODE_PWM) && (m_period > 0);
            act_pulse = (m_mode == PWM_MODE_PULSE) && (ph < m_duty);
            bnd       = (act_pwm && ((ph + 1) % m_period == 0)) ||
                        (act_pulse && (ph + 1 == m_duty));
            if (!act_pwm && !act_pulse) begin
                if (acc) apply_cfg(bus.cfg_mode, int'(bus.cfg_period), int'(bus.cfg_duty));
            end else if (bnd) begin
                if (m_pend) begin
                    apply_cfg(p_mode, p_period, p_duty);
                    m_pend = 1'b0;
                end else if (acc) begin
                    apply_cfg(bus.cfg_mode, int'(bus.cfg_period), int'(bus.cfg_duty));
                end
            end else if (acc) begin
                m_pend   = 1'b1;
                p_mode   = bus.cfg_mode;
                p_period = int'(bus.cfg_period);
                p_duty   = int'(bus.cfg_duty);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] mode, input int period, input int duty);
        bus.cfg_valid  = 1'b1;
        bus.cfg_mode   = mode;
        bus.cfg_period = period[W-1:0];
        bus.cfg_duty   = duty[W-1:0];
        tick();
        bus.cfg_valid  = 1'b0;
    endtask

    task automatic do_reset();
        bus.cfg_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst = 1'b1;
        bus.cfg_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            got = {bus.data, bus.period_start, bus.busy, bus.cfg_ready};
            n_cmp++;
            if (got !== 4'b0001) begin
                n_bad++;
                $display("FAIL reset_idle cyc=%0d got {data,ps,busy,ready}=%b expected=0001", cyc, got);
            end
        end
    endtask

    task automatic test_pwm_basic();
        logic [3:0] got, exp;
        logic prev;
        int r1, r2, f1, s1, s2;
        r1 = -1; r2 = -1; f1 = -1; s1 = -1; s2 = -1;
        do_reset();
        prev = 1'b0;
        send(PWM_MODE_PWM, 100, 25);
        for (int i = 0; i < 300; i++) begin
            if (i > 0) tick();
            got = {bus.data, bus.period_start, bus.busy, bus.cfg_ready};
            exp = model_out();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL pwm_basic cyc=%0d got=%b expected=%b", cyc, got, exp);
            end
            if (bus.data && !prev) begin
                if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
            end
            if (!bus.data && prev && f1 < 0) f1 = i;
            if (bus.period_start) begin
                if (s1 < 0) s1 = i; else if (s2 < 0) s2 = i;
            end
            prev = bus.data;
        end
        n_cmp++;
        if (f1 - r1 !== 25) begin n_bad++; $display("FAIL pwm_high_time got=%0d expected=25", f1 - r1); end
        n_cmp++;
        if (r2 - r1 !== 100) begin n_bad++; $display("FAIL pwm_rise_spacing got=%0d expected=100", r2 - r1); end
        n_cmp++;
        if (s2 - s1 !== 100) begin n_bad++; $display("FAIL pwm_ps_spacing got=%0d expected=100", s2 - s1); end
        n_cmp++;
        if (s1 !== r1) begin n_bad++; $display("FAIL pwm_ps_align got=%0d expected=%0d", s1, r1); end
    endtask

    task automatic test_midperiod_update();
        logic [3:0] got, exp;
        int hi0, hi1;
        hi0 = 0; hi1 = 0;
        do_reset();
        send(PWM_MODE_PWM, 100, 25);
        for (int p = 0; p < 200; p++) begin
            got = {bus.data, bus.period_start, bus.busy, bus.cfg_ready};
            exp = model_out();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL mid_update cyc=%0d phase=%0d got=%b expected=%b", cyc, p, got, exp);
            end
            if (p >= 41 && p <= 99) begin
                n_cmp++;
                if (bus.cfg_ready !== 1'b0) begin
                    n_bad++;
                    $display("FAIL mid_ready_low phase=%0d got=%b expected=0", p, bus.cfg_ready);
                end
            end
            if (p == 100) begin
                n_cmp++;
                if (bus.cfg_ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL mid_ready_rise phase=%0d got=%b expected=1", p, bus.cfg_ready);
                end
            end
            if (bus.data) begin
                if (p < 100) hi0++; else hi1++;
            end
            bus.cfg_valid = (p == 40);
            if (p == 40) begin
                bus.cfg_mode   = PWM_MODE_PWM;
                bus.cfg_period = 16'd100;
                bus.cfg_duty   = 16'd75;
            end
            tick();
        end
        bus.cfg_valid = 1'b0;
        n_cmp++;
        if (hi0 !== 25) begin n_bad++; $display("FAIL mid_old_duty got=%0d expected=25", hi0); end
        n_cmp++;
        if (hi1 !== 75) begin n_bad++; $display("FAIL mid_new_duty got=%0d expected=75", hi1); end
    endtask

    task automatic test_pulse();
        logic [3:0] got, exp;
        logic prev;
        int hi, bz, rises;
        hi = 0; bz = 0; rises = 0;
        do_reset();
        prev = 1'b0;
        send(PWM_MODE_PULSE, 0, 37);
        for (int i = 0; i < 1100; i++) begin
            if (i > 0) tick();
            got = {bus.data, bus.period_start, bus.busy, bus.cfg_ready};
            exp = model_out();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL pulse cyc=%0d got=%b expected=%b", cyc, got, exp);
            end
            if (bus.data) hi++;
            if (bus.busy) bz++;
            if (bus.data && !prev) rises++;
            prev = bus.data;
        end
        n_cmp++;
        if (hi !== 37) begin n_bad++; $display("FAIL pulse_width got=%0d expected=37", hi); end
        n_cmp++;
        if (bz !== 37) begin n_bad++; $display("FAIL pulse_busy got=%0d expected=37", bz); end
        n_cmp++;
        if (rises !== 1) begin n_bad++; $display("FAIL pulse_count got=%0d expected=1", rises); end
    endtask

    task automatic test_degenerate();
        int per   [3] = '{100, 100, 0};
        int dty   [3] = '{0, 120, 50};
        int exp_d [3] = '{0, 1, 0};
        int exp_ps[3] = '{3, 3, 0};
        logic [3:0] got, exp;
        int nps;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            nps = 0;
            send(PWM_MODE_PWM, per[k], dty[k]);
            for (int i = 0; i < 250; i++) begin
                if (i > 0) tick();
                got = {bus.data, bus.period_start, bus.busy, bus.cfg_ready};
                exp = model_out();
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL degen%0d cyc=%0d got=%b expected=%b", k, cyc, got, exp);
                end
                n_cmp++;
                if (int'(bus.data) !== exp_d[k]) begin
                    n_bad++;
                    $display("FAIL degen%0d_level cyc=%0d got=%b expected=%0d", k, cyc, bus.data, exp_d[k]);
                end
                if (bus.period_start) nps++;
            end
            n_cmp++;
            if (nps !== exp_ps[k]) begin
                n_bad++;
                $display("FAIL degen%0d_ps_count got=%0d expected=%0d", k, nps, exp_ps[k]);
            end
        end
    endtask

    task automatic test_midreset();
        logic [3:0] got, exp;
        do_reset();
        send(PWM_MODE_PWM, 100, 75);
        for (int p = 0; p < 60; p++) begin
            got = {bus.data, bus.period_start, bus.busy, bus.cfg_ready};
            exp = model_out();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL midrst_pre cyc=%0d got=%b expected=%b", cyc, got, exp);
            end
            bus.cfg_valid = (p == 50);
            if (p == 50) begin
                bus.cfg_mode   = PWM_MODE_PULSE;
                bus.cfg_period = 16'd0;
                bus.cfg_duty   = 16'd10;
            end
            tick();
        end
        bus.cfg_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i > 0) tick();
            got = {bus.data, bus.period_start, bus.busy, bus.cfg_ready};
            n_cmp++;
            if (got !== 4'b0001) begin
                n_bad++;
                $display("FAIL midrst_post cyc=%0d got=%b expected=0001", cyc, got);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] got, exp;
        int rate;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rate = (i < 2000) ? 10 : 2;
            bus.cfg_valid  = ($urandom_range(0, rate - 1) == 0);
            bus.cfg_mode   = 2'($urandom_range(0, 3));
            bus.cfg_period = 16'($urandom_range(0, 40));
            bus.cfg_duty   = 16'($urandom_range(0, 45));
            rst = ($urandom_range(0, 599) == 0);
            tick();
            got = {bus.data, bus.period_start, bus.busy, bus.cfg_ready};
            exp = model_out();
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%b expected=%b", cyc, got, exp);
            end
        end
        rst = 1'b0;
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        bus.cfg_valid  = 1'b0;
        bus.cfg_mode   = PWM_MODE_OFF;
        bus.cfg_period = '0;
        bus.cfg_duty   = '0;
        @(negedge clk);
        test_reset();
        test_pwm_basic();
        test_midperiod_update();
        test_pulse();
        test_degenerate();
        test_midreset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
